// File: rtl/syscall_pkg.sv
// Shared constants and FSM encoding for the syscall console unit.
package syscall_pkg;

    localparam int SYS_PRINT_INT = 1;
    localparam int SYS_PRINT_STR = 4;
    localparam int SYS_EXIT      = 10;

    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INT_CONV,
        ST_INT_EMIT,
        ST_STR_REQ,
        ST_STR_WAIT,
        ST_STR_EMIT,
        ST_HALT
    } state_e;

endpackage

// File: rtl/char_fifo.sv
// Byte FIFO with wrap-bit pointers; a push while full is accepted when a pop
// happens in the same cycle.
module char_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] din_i,
    output logic       full_o,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        wr_ok, rd_ok;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_ok    = pop_i && !empty_o;
        wr_ok    = push_i && (!full_o || rd_ok);
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        // Head byte reads as zero when empty so the output is clean after reset.
        dout_o   = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/syscall_console.sv
// Syscall service unit: print_int via double-dabble, print_string via a
// word-at-a-time memory walker, exit/halt, character FIFO and watchdog.
module syscall_console
    import syscall_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_AW      = 12,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_STR     = 256,
    parameter int WDOG_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              syscall_i,
    input  logic [DATA_W-1:0] v0_i,
    input  logic [DATA_W-1:0] a0_i,
    output logic              busy_o,
    output logic              mem_rd_en_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              ch_valid_o,
    output logic [7:0]        ch_data_o,
    input  logic              ch_ready_i,
    output logic              exit_o,
    output logic              err_o,
    output logic              wdog_o
);

    localparam int NDIG   = (DATA_W * 302) / 1000 + 1;
    localparam int BCD_W  = 4 * NDIG;
    localparam int DIG_W  = $clog2(NDIG);
    localparam int CNT_W  = $clog2(DATA_W);
    localparam int STR_CW = $clog2(MAX_STR + 1);
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam int ADR_W  = MEM_AW + 2;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic                neg_q, neg_d;
    logic [ADR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [STR_CW-1:0]   scnt_q, scnt_d;
    logic                exit_q, exit_d;
    logic                err_q, err_d;
    logic                wdog_q, wdog_d;
    logic [WDOG_W-1:0]   wcnt_q, wcnt_d;

    logic                accept, space, push, pop, fifo_full, fifo_empty;
    logic [7:0]          push_data, cur_byte;

    // Index of the most significant non-zero BCD digit (0 when the value is 0).
    function automatic logic [DIG_W-1:0] msd_idx(input logic [BCD_W-1:0] b);
        msd_idx = '0;
        for (int i = 0; i < NDIG; i++)
            if (b[4*i +: 4] != 4'd0) msd_idx = DIG_W'(i);
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    assign accept   = syscall_i && (state_q == ST_IDLE) && !exit_q;
    assign pop      = !fifo_empty && ch_ready_i;
    assign space    = !fifo_full || pop;
    assign cur_byte = word_q[{addr_q[1:0], 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        neg_d       = neg_q;
        addr_d      = addr_q;
        word_d      = word_q;
        scnt_d      = scnt_q;
        exit_d      = exit_q;
        err_d       = 1'b0;
        wdog_d      = wdog_q;
        wcnt_d      = wcnt_q;
        push        = 1'b0;
        push_data   = ASCII_ZERO;
        mem_rd_en_o = 1'b0;

        if (!exit_q) begin
            if (wcnt_q == WDOG_W'(WDOG_CYCLES - 1)) wdog_d = 1'b1;
            else                                     wcnt_d = wcnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (v0_i == DATA_W'(SYS_PRINT_INT)) begin
                        neg_d   = a0_i[DATA_W-1];
                        bin_d   = a0_i[DATA_W-1] ? -a0_i : a0_i;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_INT_CONV;
                    end else if (v0_i == DATA_W'(SYS_PRINT_STR)) begin
                        addr_d  = a0_i[ADR_W-1:0];
                        scnt_d  = '0;
                        state_d = ST_STR_REQ;
                    end else if (v0_i == DATA_W'(SYS_EXIT)) begin
                        exit_d  = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ST_INT_CONV: begin
                bcd_d = (bcd_adj << 1) | BCD_W'(bin_q[DATA_W-1]);
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    dig_d   = msd_idx(bcd_d);
                    state_d = ST_INT_EMIT;
                end
            end
            ST_INT_EMIT: begin
                if (space) begin
                    push = 1'b1;
                    if (neg_q) begin
                        push_data = ASCII_MINUS;
                        neg_d     = 1'b0;
                    end else begin
                        push_data = ASCII_ZERO + {4'd0, bcd_q[{dig_q, 2'b00} +: 4]};
                        if (dig_q == '0) state_d = ST_IDLE;
                        else             dig_d   = dig_q - 1'b1;
                    end
                end
            end
            ST_STR_REQ: begin
                mem_rd_en_o = 1'b1;
                state_d     = ST_STR_WAIT;
            end
            ST_STR_WAIT: begin
                word_d  = mem_rdata_i;
                state_d = ST_STR_EMIT;
            end
            ST_STR_EMIT: begin
                if (cur_byte == 8'h00) begin
                    state_d = ST_IDLE;
                end else if (space) begin
                    push      = 1'b1;
                    push_data = cur_byte;
                    addr_d    = addr_q + 1'b1;
                    scnt_d    = scnt_q + 1'b1;
                    if (scnt_q == STR_CW'(MAX_STR - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (addr_d[1:0] == 2'd0) begin
                        state_d = ST_STR_REQ;
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            neg_q   <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            scnt_q  <= '0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
            wdog_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            neg_q   <= neg_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            scnt_q  <= scnt_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
            wcnt_q  <= wcnt_d;
        end
    end

    char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_data),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .dout_o  (ch_data_o),
        .empty_o (fifo_empty)
    );

    assign busy_o     = (state_q != ST_IDLE) || accept;
    assign mem_addr_o = addr_q[ADR_W-1:2];
    assign ch_valid_o = !fifo_empty;
    assign exit_o     = exit_q;
    assign err_o      = err_q;
    assign wdog_o     = wdog_q;

endmodule

// File: tb/tb_syscall_console.sv
// Bench for syscall_console: vector table, directed corner sequences and
// randomized calls checked against a string-level reference.
module tb_syscall_console;

    localparam int DATA_W = 32, MEM_AW = 12, FIFO_DEPTH = 2, MAX_STR = 16, WDOG = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              syscall_i = 1'b0;
    logic [DATA_W-1:0] v0_i = '0, a0_i = '0;
    logic              busy_o, mem_rd_en_o, ch_valid_o, ch_ready_i, exit_o, err_o, wdog_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic [7:0]        ch_data_o;

    syscall_console #(
        .DATA_W(DATA_W), .MEM_AW(MEM_AW), .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_STR(MAX_STR), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst(rst), .syscall_i(syscall_i), .v0_i(v0_i), .a0_i(a0_i),
        .busy_o(busy_o), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .ch_valid_o(ch_valid_o), .ch_data_o(ch_data_o),
        .ch_ready_i(ch_ready_i), .exit_o(exit_o), .err_o(err_o), .wdog_o(wdog_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4096];
    logic [7:0]  rx[$];
    logic [11:0] rd_addrs[$];
    int          err_seen = 0;
    int          rdy_mode = 1;
    int          vec_cnt = 0, miss_cnt = 0;

    // Memory model: one-cycle read latency; consumer and error monitors.
    always @(posedge clk) begin
        if (mem_rd_en_o) begin
            mem_rdata_i <= mem[mem_addr_o];
            rd_addrs.push_back(mem_addr_o);
        end
        if (ch_valid_o && ch_ready_i) rx.push_back(ch_data_o);
        if (err_o) err_seen++;
    end

    always @(negedge clk)
        ch_ready_i = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic string rx_str();
        string s = "";
        foreach (rx[i]) s = {s, $sformatf("%c", rx[i])};
        return s;
    endfunction

    task automatic clear_mon();
        rx.delete();
        rd_addrs.delete();
        err_seen = 0;
    endtask

    task automatic put_byte(input int addr, input logic [7:0] b);
        int w, o;
        w = addr >> 2;
        o = addr & 3;
        mem[w][o*8 +: 8] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        syscall_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Issue one call, wait for busy to drop and the FIFO to drain.
    task automatic do_call(input logic [31:0] v0, input logic [31:0] a0, output int lat);
        int n;
        @(negedge clk);
        syscall_i = 1'b1;
        v0_i = v0;
        a0_i = a0;
        lat = 0;
        do begin
            @(negedge clk);
            syscall_i = 1'b0;
            lat++;
        end while (busy_o && lat < 3000);
        check("call completes", busy_o, 1'b0);
        n = 0;
        while (ch_valid_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] v0;
        logic [31:0] a0;
        string       exp;
        int          nerr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int lat, n;
        bit all_busy;
        string exp;

        foreach (mem[i]) mem[i] = '0;
        mem[12'h100] = 32'h6C6C6548;
        mem[12'h101] = 32'h0000006F;
        for (int i = 0; i < 24; i++) put_byte(32'h800 + i, 8'(8'h41 + i));

        tbl.push_back('{32'd1,  32'hFFFFFF85, "-123", 0});
        tbl.push_back('{32'd1,  32'h00000000, "0", 0});
        tbl.push_back('{32'd1,  32'h80000000, "-2147483648", 0});
        tbl.push_back('{32'd1,  32'h7FFFFFFF, "2147483647", 0});
        tbl.push_back('{32'd1,  32'd100, "100", 0});
        tbl.push_back('{32'd1,  32'hFFFFFFFF, "-1", 0});
        tbl.push_back('{32'd4,  32'h00000403, "lo", 0});
        tbl.push_back('{32'd4,  32'h00000800, "ABCDEFGHIJKLMNOP", 1});
        tbl.push_back('{32'd7,  32'h00000000, "", 1});
        tbl.push_back('{32'd0,  32'h00000001, "", 1});

        // Reset state
        #1;
        check("rst busy", busy_o, 0);
        check("rst rd_en", mem_rd_en_o, 0);
        check("rst addr", mem_addr_o, 0);
        check("rst ch_valid", ch_valid_o, 0);
        check("rst ch_data", ch_data_o, 0);
        check("rst exit", exit_o, 0);
        check("rst err", err_o, 0);
        check("rst wdog", wdog_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            clear_mon();
            rdy_mode = (i % 2 == 0) ? 1 : 2;
            do_call(tbl[i].v0, tbl[i].a0, lat);
            check_str($sformatf("tbl[%0d] text", i), rx_str(), tbl[i].exp);
            check($sformatf("tbl[%0d] err pulses", i), err_seen, tbl[i].nerr);
            if (i == 0) check("int -123 latency 35..37", (lat >= 35 && lat <= 37), 1);
        end

        // Aligned string: one read per word
        clear_mon();
        rdy_mode = 1;
        do_call(32'd4, 32'h400, lat);
        check_str("hello text", rx_str(), "Hello");
        check("hello reads", rd_addrs.size(), 2);
        check("hello rd0", rd_addrs.size() > 0 ? rd_addrs[0] : 12'hFFF, 12'h100);
        check("hello rd1", rd_addrs.size() > 1 ? rd_addrs[1] : 12'hFFF, 12'h101);
        check("hello err", err_seen, 0);

        // Backpressure: consumer stalled with a 2-entry FIFO
        clear_mon();
        rdy_mode = 0;
        @(negedge clk);
        syscall_i = 1'b1;
        v0_i = 32'd4;
        a0_i = 32'h401;
        @(negedge clk);
        syscall_i = 1'b0;
        all_busy = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!busy_o) all_busy = 1'b0;
        end
        check("stall busy held", all_busy, 1);
        check("stall nothing popped", rx.size(), 0);
        check("stall ch_valid", ch_valid_o, 1);
        rdy_mode = 1;
        n = 0;
        while ((busy_o || ch_valid_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_str("stall text", rx_str(), "ello");

        // Randomized calls against a string-level reference
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a0;
            int start, len;
            clear_mon();
            rdy_mode = 2;
            if ($urandom_range(0, 2) != 0) begin
                a0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
                exp = $sformatf("%0d", $signed(a0));
                do_call(32'd1, a0, lat);
            end else begin
                for (int w = 12'h400; w < 12'h410; w++) mem[w] = '0;
                start = 32'h1000 + $urandom_range(0, 15);
                len = $urandom_range(0, 10);
                exp = "";
                for (int j = 0; j < len; j++) begin
                    logic [7:0] b;
                    b = 8'($urandom_range(32'h20, 32'h7E));
                    put_byte(start + j, b);
                    exp = {exp, $sformatf("%c", b)};
                end
                do_call(32'd4, 32'(start), lat);
            end
            check_str($sformatf("rand[%0d] text", k), rx_str(), exp);
            check($sformatf("rand[%0d] err", k), err_seen, 0);
        end

        // Invalid code, exit, ignored call, watchdog quiet after exit
        apply_reset();
        clear_mon();
        rdy_mode = 1;
        do_call(32'd7, 32'd0, lat);
        check("bad code err", err_seen, 1);
        check("bad code text", rx.size(), 0);
        @(negedge clk);
        syscall_i = 1'b1;
        v0_i = 32'd10;
        #1 check("exit busy comb", busy_o, 1);
        @(negedge clk);
        syscall_i = 1'b0;
        check("exit flag", exit_o, 1);
        check("exit busy", busy_o, 1);
        syscall_i = 1'b1;
        v0_i = 32'd1;
        a0_i = 32'd5;
        @(negedge clk);
        syscall_i = 1'b0;
        repeat (60) @(negedge clk);
        check("post-exit text", rx.size(), 0);
        check("post-exit busy", busy_o, 1);
        check("post-exit exit", exit_o, 1);
        check("post-exit wdog", wdog_o, 0);

        // Watchdog timing from reset release
        apply_reset();
        n = 0;
        while (!wdog_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wdog cycle", n, WDOG);

        // Reset in the middle of a string
        clear_mon();
        rdy_mode = 0;
        @(negedge clk);
        syscall_i = 1'b1;
        v0_i = 32'd4;
        a0_i = 32'h800;
        @(negedge clk);
        syscall_i = 1'b0;
        repeat (10) @(negedge clk);
        check("mid busy", busy_o, 1);
        rst = 1'b0;
        #1;
        check("mid rst busy", busy_o, 0);
        check("mid rst rd_en", mem_rd_en_o, 0);
        check("mid rst addr", mem_addr_o, 0);
        check("mid rst ch_valid", ch_valid_o, 0);
        check("mid rst ch_data", ch_data_o, 0);
        check("mid rst wdog", wdog_o, 0);
        check("mid rst exit", exit_o, 0);
        @(negedge clk);
        rst = 1'b1;
        rdy_mode = 1;
        repeat (5) @(negedge clk);
        check("mid rst fifo empty", ch_valid_o, 0);
        check("mid rst text", rx.size(), 0);
        check("mid rst err", err_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
